// File: rtl/serdes_unpack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serdes_unpack_pkg
// Description : Shared sizing helper and state encodings for serdes_unpack.
// Revision    : 1.0 - initial release
// ============================================================================
package serdes_unpack_pkg;

    localparam logic [1:0] SU_IDLE   = 2'd0;
    localparam logic [1:0] SU_UNPACK = 2'd1;
    localparam logic [1:0] SU_DRAIN  = 2'd2;

    // Bits needed to index `value` distinct states (minimum 1).
    function automatic int C_LOG_2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
// Module      : fifo
// Description : Synchronous FIFO with a registered (1-cycle latency) read port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  do_wr, do_rd;

    // Extra pointer bit distinguishes full from empty when addresses match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign rd_data = rd_data_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + (ADDR_WIDTH+1)'(do_wr);
        rd_ptr_d  = rd_ptr_q + (ADDR_WIDTH+1)'(do_rd);
        rd_data_d = do_rd ? mem_q[rd_ptr_q[ADDR_WIDTH-1:0]] : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serdes_unpack.sv
`default_nettype none
// ============================================================================
// Module      : serdes_unpack
// Description : Unpacks densely packed operand words into count-operand words.
// Revision    : 1.0 - initial release
// ============================================================================
module serdes_unpack
    import serdes_unpack_pkg::*;
#(
    parameter int IN_COUNT  = 10,
    parameter int OUT_COUNT = 10,
    parameter int OP_WIDTH  = 16,
    parameter int IN_WIDTH  = IN_COUNT * OP_WIDTH,
    parameter int OUT_WIDTH = OUT_COUNT * OP_WIDTH,
    parameter int COUNT_W   = C_LOG_2(OUT_COUNT + 1),
    parameter int VOPS_W    = C_LOG_2(IN_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COUNT_W-1:0]   count,
    input  logic                 s_read_req,
    output logic                 s_read_ready,
    input  logic [IN_WIDTH-1:0]  s_read_data,
    input  logic                 s_read_last,
    input  logic [VOPS_W-1:0]    s_read_vops,
    output logic                 m_read_req,
    input  logic                 m_read_ready,
    output logic [OUT_WIDTH-1:0] m_read_data
);
    localparam int FIFO_W    = IN_WIDTH + VOPS_W + 1;
    localparam bit BYPASS_OK = (IN_COUNT == OUT_COUNT);

    logic [1:0]           state_q, state_d;
    logic [VOPS_W-1:0]    rd_idx_q, rd_idx_d;
    logic [COUNT_W-1:0]   wr_idx_q, wr_idx_d;
    logic [COUNT_W-1:0]   cnt_lat_q, cnt_lat_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;

    logic                 fifo_full, fifo_empty, pop;
    logic [FIFO_W-1:0]    fifo_rd_data;
    logic                 piso_last;
    logic [VOPS_W-1:0]    piso_vops;
    logic [IN_WIDTH-1:0]  piso_data;

    logic [VOPS_W-1:0]    rd_lim;
    logic [COUNT_W-1:0]   count_map, cnt_eff, wr_next;
    logic                 move_en, handshake, bypass, word_done, exhaust, go_drain;

    // The FIFO's registered read port doubles as the PISO holding register.
    fifo #(
        .DATA_WIDTH (FIFO_W),
        .ADDR_WIDTH (3)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (s_read_req),
        .wr_data ({s_read_last, s_read_vops, s_read_data}),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    assign {piso_last, piso_vops, piso_data} = fifo_rd_data;
    assign s_read_ready = !fifo_full;
    assign m_read_req   = out_valid_q;
    assign m_read_data  = acc_q;

    assign rd_lim    = piso_last ? piso_vops : VOPS_W'(IN_COUNT);
    assign count_map = (count == '0) ? COUNT_W'(OUT_COUNT) : count;
    assign cnt_eff   = (wr_idx_q == '0) ? count_map : cnt_lat_q;
    assign handshake = out_valid_q && m_read_ready;
    assign move_en   = (state_q == SU_UNPACK) && !(out_valid_q && !m_read_ready);

    always_comb begin
        bypass    = BYPASS_OK && (cnt_eff == COUNT_W'(OUT_COUNT)) && (rd_idx_q == '0) &&
                    (wr_idx_q == '0) && (rd_lim == VOPS_W'(IN_COUNT));
        word_done = move_en && (bypass || (wr_idx_q == cnt_eff - 1'b1));
        exhaust   = move_en && (bypass || (rd_idx_q == rd_lim - 1'b1));
        wr_next   = word_done ? '0 : wr_idx_q + 1'b1;
        // A last word that leaves a partially filled accumulator must flush it.
        go_drain  = exhaust && piso_last && (wr_next != '0);
    end

    always_comb begin
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        cnt_lat_d   = cnt_lat_q;
        rd_idx_d    = rd_idx_q;
        wr_idx_d    = wr_idx_q;
        if (handshake) begin
            acc_d       = '0;
            out_valid_d = 1'b0;
        end
        if (move_en) begin
            if (bypass) begin
                acc_d = OUT_WIDTH'(piso_data);
            end else begin
                acc_d[wr_idx_q*OP_WIDTH +: OP_WIDTH] = piso_data[rd_idx_q*OP_WIDTH +: OP_WIDTH];
            end
            if (wr_idx_q == '0) begin
                cnt_lat_d = count_map;
            end
            rd_idx_d = exhaust ? '0 : rd_idx_q + 1'b1;
            wr_idx_d = go_drain ? '0 : wr_next;
        end
        if (word_done || go_drain) begin
            out_valid_d = 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SU_IDLE;
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
            cnt_lat_q   <= '0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            rd_idx_q    <= rd_idx_d;
            wr_idx_q    <= wr_idx_d;
            cnt_lat_q   <= cnt_lat_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            SU_IDLE: begin
                if (!fifo_empty) state_d = SU_UNPACK;
            end
            SU_UNPACK: begin
                if (go_drain) state_d = SU_DRAIN;
                else if (exhaust && fifo_empty) state_d = SU_IDLE;
            end
            SU_DRAIN: begin
                if (handshake) state_d = SU_IDLE;
            end
            default: state_d = SU_IDLE;
        endcase
    end

    // FSM: outputs; the refill pop overlaps consumption of the final operand.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            SU_IDLE:   pop = !fifo_empty;
            SU_UNPACK: pop = exhaust && !go_drain && !fifo_empty;
            default:   pop = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/serdes_unpack.md
# serdes_unpack

Unpacks a stream of densely packed operand words into output words that each carry a configured number of operands. Each input word holds `IN_COUNT` operands. Each output word holds `count` operands in its low lanes, with the upper lanes zero-filled. This block is the read-side counterpart of the `serdes` packer. It sits between a packed memory read stream and a PE-array input buffer. End-of-stream is marked on the last input word: surplus padding operands in that word are dropped, and any partial output word is emitted zero-padded.

## Interface
- `IN_COUNT`, 10, operands per packed input word
- `OUT_COUNT`, 10, operand lanes per output word
- `OP_WIDTH`, 16, bits per operand
- `IN_WIDTH`, `IN_COUNT*OP_WIDTH`, input data width
- `OUT_WIDTH`, `OUT_COUNT*OP_WIDTH`, output data width
- `COUNT_W`, `C_LOG_2(OUT_COUNT+1)`, width of `count`
- `VOPS_W`, `C_LOG_2(IN_COUNT+1)`, width of `s_read_vops`

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `count`  in  `COUNT_W`  operands per output word; 0 means `OUT_COUNT`
- `s_read_req`  in  1  push a packed word
- `s_read_ready`  out  1  input FIFO not full
- `s_read_data`  in  `IN_WIDTH`  packed operands, lane 0 = bits `[OP_WIDTH-1:0]`
- `s_read_last`  in  1  this word ends the stream
- `s_read_vops`  in  `VOPS_W`  valid operands in a last word (1..`IN_COUNT`); ignored unless `s_read_last`
- `m_read_req`  out  1  output word valid
- `m_read_ready`  in  1  consumer accepts
- `m_read_data`  out  `OUT_WIDTH`  unpacked word

## Operation
- **Input FIFO:** 8-entry FIFO stores `{last, vops, data}`.
  - Push on `s_read_req`. A push while full is illegal; the bench asserts against it.
- **PISO register:** holds the current input word.
  - `rd_idx` (0..`IN_COUNT`-1) indexes the current operand.
  - `rd_lim` = `vops` if `last`, else `IN_COUNT`.
  - The FIFO pops when the PISO is empty, or when it consumes its final operand in the same cycle.
- **Accumulator:** doubles as the output register.
  - `wr_idx` (0..`OUT_COUNT`-1) gives the next lane.
  - `cnt_lat` is `count` (0 mapped to `OUT_COUNT`), sampled when an operand is written at `wr_idx==0` and held for that word.
- **Move condition:** one operand moves PISO→accumulator per cycle when both hold:
  - the PISO is valid;
  - the accumulator is not full-and-stalled.
- **Word completion:**
  - After writing lane `cnt_lat-1`, `m_read_req` rises.
  - On `m_read_req && m_read_ready`, the accumulator clears (all lanes 0, `wr_idx=0`).
  - In that same cycle, a new operand may be written to lane 0.
- **Bypass:** applies when `cnt_lat==OUT_COUNT==IN_COUNT`, `rd_idx==0`, `wr_idx==0` and `rd_lim==IN_COUNT`. The whole word moves in one cycle.
- **Last word:**
  - When `rd_idx` reaches `rd_lim` on a `last` word, the remaining operands are discarded.
  - If `wr_idx>0`, the partial word is emitted with upper lanes zero.
  - `wr_idx==0` emits nothing.
- **FSM:**
  - `IDLE` (PISO empty) → `UNPACK` when the FIFO is not empty.
  - `UNPACK` → `IDLE` when the PISO is exhausted and the FIFO is empty.
  - `UNPACK` → `DRAIN` when a last word is exhausted and `wr_idx>0`.
  - `DRAIN` holds `m_read_req`, then → `IDLE` on handshake.
- **Output holding:** a full accumulator stalls unpacking, and `m_read_data` must hold stable while `m_read_req && !m_read_ready`.
- **Reset:** reset mid-stream discards the FIFO, PISO and accumulator contents.

## Timing
- **Reset values:**
  - `m_read_req=0`, `m_read_data=0`;
  - `s_read_ready=1` one cycle after reset deasserts;
  - state `IDLE`, `rd_idx=0`, `wr_idx=0`.
- **FIFO read latency:** 1 cycle. A pop in cycle t makes the PISO valid in t+1.
- **Startup latency:** push into an empty block at cycle 0 → operand 0 written at end of cycle 2 → `m_read_req` at cycle 3 (for `count=1`).
- **Throughput:**
  - 1 operand/cycle sustained; no bubble across input-word or output-word boundaries while `m_read_ready=1`.
  - Bypass mode: 1 word/cycle.
- **Simultaneous events:** handshake plus a lane-0 write in the same cycle is legal. FIFO push plus pop while full is not allowed.

## Structure
- `C_LOG_2` comes from `common.vh`. Add `SU_IDLE`/`SU_UNPACK`/`SU_DRAIN` state encodings there.
- Reuse the existing `fifo` sub-module with `DATA_WIDTH=IN_WIDTH+VOPS_W+1` and `ADDR_WIDTH=3`. No other sub-modules.

## Test plan
All scenarios use `IN_COUNT=OUT_COUNT=4` and `OP_WIDTH=16` unless stated.

- **Basic split:** `count=2`, push ops [1,2,3,4] with `last=1`, `vops=4` → two outputs: lanes {1,2,0,0} then {3,4,0,0}; first `m_read_req` at cycle 4.
- **Cross-word packing:** `count=3`, push [1,2,3,4] then [5,6,7,8] with `last`, `vops=4` → {1,2,3,0}, {4,5,6,0}, {7,8,0,0} via `DRAIN`.
- **Padding drop:** `count=2`, last word [9,0,0,0] with `vops=1` → single output {9,0,0,0}; no further `m_read_req`.
- **Backpressure:** `count=1`, `m_read_ready=0` for 20 cycles while pushing 12 words →
  - `s_read_ready` drops after the FIFO fills;
  - `m_read_data` is stable while stalled;
  - all 48 operands arrive in order after release.
- **Bypass:** `count=0`, 6 back-to-back words, `m_read_ready=1` → 6 outputs on 6 consecutive cycles, each equal to its input.
- **Reset mid-stream:** reset during `UNPACK` → outputs return to 0; a fresh stream then unpacks correctly with no stale operands.
